// File: rtl/rx_chunker.sv
// UART frame chunker: assembles [type, length N, N payload bytes] frames into a
// parallel chunk register, dropping oversize or stalled frames with an error pulse.
module rx_chunker #(
   parameter int unsigned RX_CONTENT_BUFFER_BYTE_SIZE  = 33,
   parameter int unsigned RX_CONTENT_BUFFER_INDEX_SIZE = 32,
   parameter int unsigned RX_TIMEOUT_CYCLES            = 1000000
) (
   input  logic                                       CLK,
   input  logic                                       RSTN,
   input  logic [7:0]                                 rx_byte,
   input  logic                                       rx_byte_valid,
   output logic [7:0]                                 rx_chunk_type,
   output logic [RX_CONTENT_BUFFER_BYTE_SIZE*8-1:0]   rx_chunk_bytes,
   output logic [RX_CONTENT_BUFFER_INDEX_SIZE-1:0]    rx_chunk_byte_size,
   output logic                                       rx_is_chunk_ready,
   output logic                                       rx_chunk_error
);

   localparam int unsigned NB = RX_CONTENT_BUFFER_BYTE_SIZE;
   localparam int unsigned BW = NB * 8;
   localparam int unsigned IW = RX_CONTENT_BUFFER_INDEX_SIZE;
   localparam int unsigned TW = $clog2(RX_TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, DISCARD} state_t;

   state_t          state;
   logic [7:0]      asm_type;
   logic [BW-1:0]   asm_buf;
   logic [7:0]      asm_len;
   logic [7:0]      idx;
   logic [TW-1:0]   tmo_cnt;

   logic [BW-1:0]   buf_next;
   logic            last_byte;

   // Assembly buffer with the incoming byte merged at the current index
   always_comb begin
      buf_next = asm_buf;
      if (32'(idx) < NB) begin
         buf_next[8*int'(idx) +: 8] = rx_byte;
      end
      last_byte = ((32'(idx) + 32'd1) == 32'(asm_len));
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state              <= IDLE;
         asm_type           <= '0;
         asm_buf            <= '0;
         asm_len            <= '0;
         idx                <= '0;
         tmo_cnt            <= '0;
         rx_chunk_type      <= '0;
         rx_chunk_bytes     <= '0;
         rx_chunk_byte_size <= '0;
         rx_is_chunk_ready  <= 1'b0;
         rx_chunk_error     <= 1'b0;
      end else begin
         rx_is_chunk_ready <= 1'b0;
         rx_chunk_error    <= 1'b0;
         if (rx_byte_valid) begin
            // A valid byte always beats a coincident timeout
            tmo_cnt <= '0;
            case (state)
               IDLE: begin
                  asm_type <= rx_byte;
                  asm_buf  <= '0;
                  idx      <= '0;
                  state    <= LEN;
               end
               LEN: begin
                  asm_len <= rx_byte;
                  if (rx_byte == 8'd0) begin
                     rx_chunk_type      <= asm_type;
                     rx_chunk_bytes     <= asm_buf;
                     rx_chunk_byte_size <= '0;
                     rx_is_chunk_ready  <= 1'b1;
                     state              <= IDLE;
                  end else if (32'(rx_byte) <= NB) begin
                     state <= PAYLOAD;
                  end else begin
                     state <= DISCARD;
                  end
               end
               PAYLOAD: begin
                  asm_buf <= buf_next;
                  idx     <= idx + 8'd1;
                  if (last_byte) begin
                     rx_chunk_type      <= asm_type;
                     rx_chunk_bytes     <= buf_next;
                     rx_chunk_byte_size <= IW'(asm_len);
                     rx_is_chunk_ready  <= 1'b1;
                     state              <= IDLE;
                  end
               end
               DISCARD: begin
                  asm_len <= asm_len - 8'd1;
                  if (asm_len == 8'd1) begin
                     rx_chunk_error <= 1'b1;
                     state          <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt == TW'(RX_TIMEOUT_CYCLES - 1)) begin
            // Inter-byte silence inside a frame: abandon it
            tmo_cnt        <= '0;
            rx_chunk_error <= 1'b1;
            state          <= IDLE;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

endmodule
